// File: rtl/bitset_report_hub.sv
// rtl/bitset_report_hub.sv - per-channel bit-vector tracker with full/snapshot report stream
module bitset_report_hub #(
  parameter int WIDTH    = 6,
  parameter int NUM_CH   = 2,
  parameter bit AUTO_CLR = 1'b1,
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_valid,
  input  logic [CW-1:0]    set_ch,
  input  logic [BW-1:0]    set_bit,
  input  logic             clr_valid,
  input  logic [CW-1:0]    clr_ch,
  input  logic             snap_valid,
  input  logic [CW-1:0]    snap_ch,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_ch,
  output logic [WIDTH-1:0] out_data,
  output logic             out_full
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state;
  logic [WIDTH-1:0]  vec      [NUM_CH];
  logic [WIDTH-1:0]  vec_nxt  [NUM_CH];
  logic [NUM_CH-1:0] pend_full, pend_full_nxt;
  logic [NUM_CH-1:0] pend_snap, pend_snap_nxt;
  logic [CW-1:0]     rr;
  logic [CW-1:0]     pick_ch;
  logic              pick_found;
  logic              rep_snap;
  logic              accept;

  // out_valid is only ever high in SEND, so this is the report handshake
  assign accept = out_valid && out_ready;

  // Next vector and pending flags per channel: clear first, then set, then events
  always_comb begin
    logic clr_hit;
    logic own_send;
    for (int c = 0; c < NUM_CH; c++) begin
      clr_hit  = clr_valid && (int'(clr_ch) == c);
      own_send = (state == SEND) && (int'(out_ch) == c);

      vec_nxt[c] = vec[c];
      if (clr_hit || (AUTO_CLR && accept && out_full && own_send))
        vec_nxt[c] = '0;
      if (set_valid && (int'(set_ch) == c) && (int'(set_bit) < WIDTH))
        vec_nxt[c] = vec_nxt[c] | (WIDTH'(1) << set_bit);

      pend_full_nxt[c] = pend_full[c];
      pend_snap_nxt[c] = pend_snap[c];
      // a clear while this channel's report is on the bus leaves its flags alone
      if (clr_hit && !own_send) begin
        pend_full_nxt[c] = 1'b0;
        pend_snap_nxt[c] = 1'b0;
      end
      // retire only the flags that were captured into the accepted report
      if (accept && own_send) begin
        if (out_full) pend_full_nxt[c] = 1'b0;
        if (rep_snap) pend_snap_nxt[c] = 1'b0;
      end
      // new events in the same cycle win over retirement
      if ((&vec_nxt[c]) && !(&vec[c]))
        pend_full_nxt[c] = 1'b1;
      if (snap_valid && (int'(snap_ch) == c))
        pend_snap_nxt[c] = 1'b1;
    end
  end

  // Round-robin choice: first pending channel at or after rr, wrapping
  always_comb begin
    int idx;
    idx        = 0;
    pick_found = 1'b0;
    pick_ch    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(rr) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!pick_found && (pend_full[idx] || pend_snap[idx])) begin
        pick_found = 1'b1;
        pick_ch    = CW'(idx);
      end
    end
  end

  // Vector storage and sticky pending flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec       <= '{default: '0};
      pend_full <= '0;
      pend_snap <= '0;
    end else begin
      vec       <= vec_nxt;
      pend_full <= pend_full_nxt;
      pend_snap <= pend_snap_nxt;
    end
  end

  // Report FSM: capture a chosen channel, hold it until accepted, then rotate rr
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr        <= '0;
      rep_snap  <= 1'b0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
      out_full  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            state     <= SEND;
            out_valid <= 1'b1;
            out_ch    <= pick_ch;
            out_data  <= vec_nxt[pick_ch];
            out_full  <= pend_full[pick_ch];
            rep_snap  <= pend_snap[pick_ch];
          end
        end
        SEND: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            rr        <= (int'(out_ch) == NUM_CH - 1) ? '0 : out_ch + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bitset_report_hub.sv
// tb/tb_bitset_report_hub.sv - directed self-checking bench for bitset_report_hub
module tb_bitset_report_hub;

  logic       clk = 1'b0;
  logic       rst;
  logic       set_valid, clr_valid, snap_valid, out_ready;
  logic [0:0] set_ch, clr_ch, snap_ch;
  logic [2:0] set_bit;
  logic       out_valid, out_full;
  logic [0:0] out_ch;
  logic [5:0] out_data;

  logic       b_set_valid, b_clr_valid, b_snap_valid, b_out_ready;
  logic [1:0] b_set_ch, b_clr_ch, b_snap_ch;
  logic [2:0] b_set_bit;
  logic       b_out_valid, b_out_full;
  logic [1:0] b_out_ch;
  logic [5:0] b_out_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bitset_report_hub #(.WIDTH(6), .NUM_CH(2), .AUTO_CLR(1'b1)) u_dut (
    .clk(clk), .rst(rst),
    .set_valid(set_valid), .set_ch(set_ch), .set_bit(set_bit),
    .clr_valid(clr_valid), .clr_ch(clr_ch),
    .snap_valid(snap_valid), .snap_ch(snap_ch),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ch(out_ch), .out_data(out_data), .out_full(out_full)
  );

  bitset_report_hub #(.WIDTH(6), .NUM_CH(3), .AUTO_CLR(1'b1)) u_dut3 (
    .clk(clk), .rst(rst),
    .set_valid(b_set_valid), .set_ch(b_set_ch), .set_bit(b_set_bit),
    .clr_valid(b_clr_valid), .clr_ch(b_clr_ch),
    .snap_valid(b_snap_valid), .snap_ch(b_snap_ch),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_ch(b_out_ch), .out_data(b_out_data), .out_full(b_out_full)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // packed as {valid, full, ch, data}
  task automatic chk_rep(input string tag, input logic ch, input logic [5:0] d, input logic f);
    chk(tag, {23'd0, out_valid, out_full, out_ch, out_data}, {23'd0, 1'b1, f, ch, d});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_set(input logic ch, input logic [2:0] b);
    set_valid = 1'b1; set_ch = ch; set_bit = b;
    step();
    set_valid = 1'b0;
  endtask

  task automatic do_snap(input logic ch);
    snap_valid = 1'b1; snap_ch = ch;
    step();
    snap_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    set_valid = 0; set_ch = 0; set_bit = 0; clr_valid = 0; clr_ch = 0;
    snap_valid = 0; snap_ch = 0; out_ready = 0;
    b_set_valid = 0; b_set_ch = 0; b_set_bit = 0; b_clr_valid = 0; b_clr_ch = 0;
    b_snap_valid = 0; b_snap_ch = 0; b_out_ready = 0;
    step(); step();
    chk("reset_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_outs", {23'd0, out_full, out_ch, out_data}, 32'd0);
    chk("reset_valid_b", {31'd0, b_out_valid}, 32'd0);
    rst = 1'b0;

    // full detection on ch0, then auto-clear on accept
    out_ready = 1'b1;
    for (int b = 0; b < 5; b++) do_set(1'b0, 3'(b));
    chk("full_early", {31'd0, out_valid}, 32'd0);
    set_valid = 1'b1; set_ch = 0; set_bit = 3'd5;
    step();
    set_valid = 1'b0;
    chk("full_edge_n", {31'd0, out_valid}, 32'd0);
    step();
    chk_rep("full_report", 1'b0, 6'h3f, 1'b1);
    step();
    chk("full_accept", {31'd0, out_valid}, 32'd0);
    step(); step();
    chk("full_once", {31'd0, out_valid}, 32'd0);
    do_snap(1'b0);
    step();
    chk_rep("full_autoclr", 1'b0, 6'h00, 1'b0);
    step();

    // snapshot on ch1 leaves the vector intact
    do_set(1'b1, 3'd0);
    do_set(1'b1, 3'd3);
    do_snap(1'b1);
    step();
    chk_rep("snap_report", 1'b1, 6'h09, 1'b0);
    step();
    chk("snap_accept", {31'd0, out_valid}, 32'd0);
    do_snap(1'b1);
    step();
    chk_rep("snap_kept", 1'b1, 6'h09, 1'b0);
    step();

    // backpressure: outputs frozen while storage keeps updating
    out_ready = 1'b0;
    do_snap(1'b0);
    step();
    chk_rep("bp_start", 1'b0, 6'h00, 1'b0);
    do_set(1'b0, 3'd1);
    chk_rep("bp_hold", 1'b0, 6'h00, 1'b0);
    for (int k = 1; k < 5; k++) begin
      step();
      chk_rep("bp_hold", 1'b0, 6'h00, 1'b0);
    end
    out_ready = 1'b1;
    step();
    chk("bp_accept", {31'd0, out_valid}, 32'd0);
    do_snap(1'b0);
    step();
    chk_rep("bp_vec_updated", 1'b0, 6'h02, 1'b0);
    step();

    // reset asserted in the middle of a SEND
    out_ready = 1'b0;
    do_snap(1'b1);
    step();
    chk_rep("rst_pre", 1'b1, 6'h09, 1'b0);
    rst = 1'b1;
    #1;
    chk("rst_async_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_async_outs", {23'd0, out_full, out_ch, out_data}, 32'd0);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    chk("rst_no_stale", {31'd0, out_valid}, 32'd0);
    do_snap(1'b0);
    step();
    chk_rep("rst_vec0", 1'b0, 6'h00, 1'b0);
    step();
    do_snap(1'b1);
    step();
    chk_rep("rst_vec1", 1'b1, 6'h00, 1'b0);
    step();
    chk("rst_done", {31'd0, out_valid}, 32'd0);

    // fairness: both channels pending together, rr at 0 -> 0 then 1, twice
    for (int r = 0; r < 2; r++) begin
      for (int b = 0; b < 5; b++) do_set(1'b1, 3'(b));
      set_valid = 1'b1; set_ch = 1; set_bit = 3'd5;
      snap_valid = 1'b1; snap_ch = 0;
      step();
      set_valid = 1'b0; snap_valid = 1'b0;
      step();
      chk_rep("fair_first_ch0", 1'b0, 6'h00, 1'b0);
      step();
      chk("fair_gap", {31'd0, out_valid}, 32'd0);
      step();
      chk_rep("fair_second_ch1", 1'b1, 6'h3f, 1'b1);
      step();
      chk("fair_done", {31'd0, out_valid}, 32'd0);
    end

    // same-cycle clear + set leaves one-hot
    do_set(1'b0, 3'd0);
    clr_valid = 1'b1; clr_ch = 0;
    set_valid = 1'b1; set_ch = 0; set_bit = 3'd2;
    step();
    clr_valid = 1'b0; set_valid = 1'b0;
    do_snap(1'b0);
    step();
    chk_rep("clr_set_onehot", 1'b0, 6'h04, 1'b0);
    step();

    // out-of-range bit indices are ignored
    do_set(1'b0, 3'd7);
    do_set(1'b0, 3'd6);
    do_snap(1'b0);
    step();
    chk_rep("bad_bit_ignored", 1'b0, 6'h04, 1'b0);
    step();

    // snap arriving in the accept cycle of its own report -> one more report
    out_ready = 1'b0;
    do_snap(1'b0);
    step();
    chk_rep("acc_snap_pre", 1'b0, 6'h04, 1'b0);
    out_ready = 1'b1;
    snap_valid = 1'b1; snap_ch = 0;
    step();
    snap_valid = 1'b0;
    chk("acc_snap_accept", {31'd0, out_valid}, 32'd0);
    step();
    chk_rep("acc_snap_again", 1'b0, 6'h04, 1'b0);
    step();
    chk("acc_snap_accept2", {31'd0, out_valid}, 32'd0);
    step(); step(); step();
    chk("acc_snap_once", {31'd0, out_valid}, 32'd0);

    // out-of-range channel on the three-channel instance
    b_out_ready = 1'b1;
    for (int b = 0; b < 6; b++) begin
      b_set_valid = 1'b1; b_set_ch = 2'd3; b_set_bit = 3'(b);
      step();
    end
    b_set_valid = 1'b0;
    step();
    chk("bad_ch_no_full", {31'd0, b_out_valid}, 32'd0);
    b_snap_valid = 1'b1; b_snap_ch = 2'd3;
    step();
    b_snap_valid = 1'b0;
    step();
    chk("bad_ch_no_snap", {31'd0, b_out_valid}, 32'd0);
    b_snap_valid = 1'b1; b_snap_ch = 2'd0;
    step();
    b_snap_valid = 1'b0;
    step();
    chk("bad_ch_ch0_clean", {22'd0, b_out_valid, b_out_full, b_out_ch, b_out_data},
        {22'd0, 1'b1, 1'b0, 2'd0, 6'h00});
    step();
    b_set_valid = 1'b1; b_set_ch = 2'd2; b_set_bit = 3'd0;
    step();
    b_set_valid = 1'b0;
    b_snap_valid = 1'b1; b_snap_ch = 2'd2;
    step();
    b_snap_valid = 1'b0;
    step();
    chk("ch2_report", {22'd0, b_out_valid, b_out_full, b_out_ch, b_out_data},
        {22'd0, 1'b1, 1'b0, 2'd2, 6'h01});
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
